// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_DATA  = 1'b1;

    localparam int unsigned DEFAULT_TIMEOUT = 255;
    localparam int unsigned TIMEOUT_CNT_W   = 16;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Single-port memory bus: the arbiter drives it as master, the memory answers as slave.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_port_arbiter_timeout_ctr.sv
// Watchdog counter for an outstanding memory access; expire flags the last allowed cycle.
import arb_pkg::*;

module arb_timeout_ctr #(
    parameter int unsigned LIMIT = DEFAULT_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam logic [TIMEOUT_CNT_W-1:0] LAST = TIMEOUT_CNT_W'(LIMIT - 1);

    logic [TIMEOUT_CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en)
            cnt <= cnt + 1'b1;
    end

    assign expire = (cnt == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data load/store onto one memory port with timeout abort.
// Define ARB_ROUND_ROBIN_EN to alternate contested grants; otherwise data has fixed priority.
import arb_pkg::*;

module mem_port_arbiter #(
    parameter int          ADDR_W         = 32,
    parameter int          DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err,
    mem_port_arbiter_if.master mem
);
    arb_state_e state;
    logic       grant_any;
    logic       grant_d;
    logic       ctr_clr;
    logic       ctr_en;
    logic       expire;
    logic       granted;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant;
    logic gnt_id;
`endif

    always_comb begin
        grant_any = d_req | if_req;
`ifdef ARB_ROUND_ROBIN_EN
        // Contested: hand the port to whoever did not have it last time.
        grant_d = d_req & ~(if_req & (last_grant == REQ_DATA));
`else
        grant_d = d_req;
`endif
    end

    assign granted = (state == GNT_I) || (state == GNT_D);
    assign ctr_clr = (state == IDLE) && grant_any;
    assign ctr_en  = granted && !mem.ack;

    arb_timeout_ctr #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (ctr_clr),
        .en     (ctr_en),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mem.req   <= 1'b0;
            mem.we    <= 1'b0;
            mem.addr  <= '0;
            mem.wdata <= '0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            err       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant <= REQ_FETCH;
            gnt_id     <= REQ_FETCH;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        mem.req <= 1'b1;
                        if (grant_d) begin
                            mem.we    <= d_we;
                            mem.addr  <= d_addr;
                            mem.wdata <= d_wdata;
                            state     <= GNT_D;
`ifdef ARB_ROUND_ROBIN_EN
                            gnt_id    <= REQ_DATA;
`endif
                        end else begin
                            mem.we    <= 1'b0;
                            mem.addr  <= if_addr;
                            mem.wdata <= '0;
                            state     <= GNT_I;
`ifdef ARB_ROUND_ROBIN_EN
                            gnt_id    <= REQ_FETCH;
`endif
                        end
                    end
                end
                GNT_I, GNT_D: begin
                    // An ack on the expiry cycle still counts as a normal completion.
                    if (mem.ack) begin
                        mem.req <= 1'b0;
                        err     <= 1'b0;
                        state   <= RESP;
                        if (state == GNT_I) begin
                            if_done  <= 1'b1;
                            if_rdata <= mem.rdata;
                        end else begin
                            d_done  <= 1'b1;
                            d_rdata <= mem.we ? '0 : mem.rdata;
                        end
                    end else if (expire) begin
                        mem.req <= 1'b0;
                        err     <= 1'b1;
                        state   <= RESP;
                        if (state == GNT_I) begin
                            if_done  <= 1'b1;
                            if_rdata <= '0;
                        end else begin
                            d_done  <= 1'b1;
                            d_rdata <= '0;
                        end
                    end
                end
                RESP: begin
                    if_done  <= 1'b0;
                    d_done   <= 1'b0;
                    if_rdata <= '0;
                    d_rdata  <= '0;
                    err      <= 1'b0;
                    state    <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant <= gnt_id;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (TIMEOUT_CYCLES=8).
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_done;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_done;
    logic [DW-1:0] d_rdata;
    logic          err;

    int n_chk  = 0;
    int n_pass = 0;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_done  (if_done),
        .if_rdata (if_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_done   (d_done),
        .d_rdata  (d_rdata),
        .err      (err),
        .mem      (mem_bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(input string tag);
        int i;
        for (i = 0; i < 20; i++) begin
            step();
            if (mem_bus.req === 1'b1) break;
        end
        if (i == 20) chk({tag, "_grant_timeout"}, 64'(mem_bus.req), 64'd1);
    endtask

    logic exp_d [8];
    int   nd, ni, k, cnt;
    logic is_d;

    initial begin
        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        mem_bus.ack = 1'b0; mem_bus.rdata = '0;

        // Reset hold with a pending fetch
        if_req = 1'b1; if_addr = 32'h40;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_mem_req", 64'(mem_bus.req), 64'd0);
            chk("rst_done_err", {61'd0, if_done, d_done, err}, 64'd0);
        end
        chk("rst_mem_addr", 64'(mem_bus.addr), 64'd0);
        rst = 1'b0;
        step();
        chk("rst_first_req", 64'(mem_bus.req), 64'd1);
        chk("rst_first_addr", 64'(mem_bus.addr), 64'h40);
        mem_bus.ack = 1'b1; mem_bus.rdata = 32'h1111;
        step();
        chk("rst_first_done", 64'(if_done), 64'd1);
        if_req = 1'b0; mem_bus.ack = 1'b0;
        step();

        // Single fetch, ack two cycles after mem_req
        if_req = 1'b1; if_addr = 32'h10;
        step();
        chk("fetch_req", 64'(mem_bus.req), 64'd1);
        chk("fetch_addr", 64'(mem_bus.addr), 64'h10);
        chk("fetch_we", {63'd0, mem_bus.we}, 64'd0);
        chk("fetch_wdata", 64'(mem_bus.wdata), 64'd0);
        step();
        chk("fetch_req_held", 64'(mem_bus.req), 64'd1);
        chk("fetch_no_done", 64'(if_done), 64'd0);
        mem_bus.ack = 1'b1; mem_bus.rdata = 32'h00A00093;
        step();
        chk("fetch_done", 64'(if_done), 64'd1);
        chk("fetch_rdata", 64'(if_rdata), 64'h00A00093);
        chk("fetch_err", 64'(err), 64'd0);
        chk("fetch_req_drop", 64'(mem_bus.req), 64'd0);
        if_req = 1'b0; mem_bus.ack = 1'b0;
        step();
        chk("fetch_done_pulse", 64'(if_done), 64'd0);
        chk("fetch_rdata_clr", 64'(if_rdata), 64'd0);

        // Store with immediate ack
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
        step();
        chk("st_req", 64'(mem_bus.req), 64'd1);
        chk("st_we", 64'(mem_bus.we), 64'd1);
        chk("st_addr", 64'(mem_bus.addr), 64'h100);
        chk("st_wdata", 64'(mem_bus.wdata), 64'hDEADBEEF);
        mem_bus.ack = 1'b1; mem_bus.rdata = 32'h12345678;
        step();
        chk("st_done", 64'(d_done), 64'd1);
        chk("st_rdata", 64'(d_rdata), 64'd0);
        chk("st_if_done", 64'(if_done), 64'd0);
        d_req = 1'b0; d_we = 1'b0; mem_bus.ack = 1'b0;
        step();
        chk("st_done_pulse", 64'(d_done), 64'd0);

        // Contention, 4 loads and 4 fetches, starting from reset
        rst = 1'b1; step(); rst = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        exp_d = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_d = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        if_req = 1'b1; if_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        nd = 0; ni = 0;
        for (k = 0; k < 8; k++) begin
            wait_grant("cont");
            is_d = (mem_bus.addr == 32'h300);
            chk($sformatf("cont_order%0d", k), 64'(is_d), 64'(exp_d[k]));
            mem_bus.ack = 1'b1; mem_bus.rdata = 32'hA0 + k;
            step();
            if (is_d) begin
                chk($sformatf("cont_ddone%0d", k), {62'd0, d_done, if_done}, 64'd2);
                chk($sformatf("cont_drdata%0d", k), 64'(d_rdata), 64'(32'hA0 + k));
                nd++;
                if (nd == 4) d_req = 1'b0;
            end else begin
                chk($sformatf("cont_idone%0d", k), {62'd0, d_done, if_done}, 64'd1);
                chk($sformatf("cont_irdata%0d", k), 64'(if_rdata), 64'(32'hA0 + k));
                ni++;
                if (ni == 4) if_req = 1'b0;
            end
            mem_bus.ack = 1'b0;
        end
        step();
        chk("cont_counts", {32'(nd), 32'(ni)}, {32'd4, 32'd4});

        // Timeout on a load that never acks
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; mem_bus.rdata = 32'hFFFF;
        wait_grant("tmo");
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            step();
            if (mem_bus.req !== 1'b1) break;
            cnt++;
        end
        chk("tmo_req_cycles", 64'(cnt), 64'd8);
        chk("tmo_done", 64'(d_done), 64'd1);
        chk("tmo_err", 64'(err), 64'd1);
        chk("tmo_rdata", 64'(d_rdata), 64'd0);
        d_req = 1'b0;
        step();
        chk("tmo_err_clr", 64'(err), 64'd0);
        mem_bus.ack = 1'b1;
        step();
        mem_bus.ack = 1'b0;
        step();
        chk("tmo_late_ack", {61'd0, mem_bus.req, if_done, d_done}, 64'd0);

        // Reset in the middle of a fetch
        if_req = 1'b1; if_addr = 32'h500;
        wait_grant("mrst");
        step();
        chk("mrst_in_gnt", 64'(mem_bus.req), 64'd1);
        rst = 1'b1;
        step();
        chk("mrst_req_drop", 64'(mem_bus.req), 64'd0);
        rst = 1'b0; if_req = 1'b0; mem_bus.ack = 1'b1; mem_bus.rdata = 32'h5555;
        step();
        chk("mrst_no_done", {61'd0, if_done, d_done, err}, 64'd0);
        mem_bus.ack = 1'b0;
        step();
        chk("mrst_no_done2", {62'd0, if_done, mem_bus.req}, 64'd0);
        if_req = 1'b1; if_addr = 32'h600;
        wait_grant("mrst2");
        chk("mrst_restart_addr", 64'(mem_bus.addr), 64'h600);
        mem_bus.ack = 1'b1; mem_bus.rdata = 32'h600D;
        step();
        chk("mrst_restart_done", 64'(if_done), 64'd1);
        chk("mrst_restart_rdata", 64'(if_rdata), 64'h600D);
        if_req = 1'b0; mem_bus.ack = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
